// File: rtl/red_pitaya_counter_pkg.sv
// Register map, command codes and sequencer state encoding for the counter block.
package red_pitaya_counter_pkg;

  localparam logic [31:0] RegCmd     = 32'h00;
  localparam logic [31:0] RegTimeout = 32'h04;
  localparam logic [31:0] RegCh1     = 32'h08;
  localparam logic [31:0] RegCh2     = 32'h1C;

  localparam logic [31:0] CmdReset     = 32'h02;
  localparam logic [31:0] CmdImmediate = 32'h03;
  localparam logic [31:0] CmdTriggered = 32'h04;
  localparam logic [31:0] CmdTrigger   = 32'h06;

  typedef enum logic [3:0] {
    StIdle,
    StWrTo,
    StClr,
    StArm,
    StWait,
    StPoll,
    StRd1,
    StRd2,
    StPush,
    StDone,
    StError,
    StAbort
  } scan_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  function automatic bus_req_t bus_wr(logic [31:0] addr, logic [31:0] wdata);
    bus_req_t r;
    r.we    = 1'b1;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

  function automatic bus_req_t bus_rd(logic [31:0] addr);
    bus_req_t r;
    r.we    = 1'b0;
    r.addr  = addr;
    r.wdata = '0;
    return r;
  endfunction

endpackage

// File: rtl/red_pitaya_bus_master.sv
// Single-outstanding system-bus master: turns a 1-cycle request into a strobe,
// waits for ack/err and gives up after BusTo cycles.
module red_pitaya_bus_master #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned BusTo = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_wdata_o,
  output logic          m_wen_o,
  output logic          m_ren_o,
  input  logic [DW-1:0] m_rdata_i,
  input  logic          m_ack_i,
  input  logic          m_err_i,
  output logic          done_o,
  output logic          err_o,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned CntW = (BusTo > 1) ? $clog2(BusTo) : 1;

  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [CntW-1:0] cnt_q;
  logic [DW-1:0]   rdata_q;
  logic            active;

  // addr/wdata come from registers the requester holds until done_o.
  assign m_addr_o  = addr_i;
  assign m_wdata_o = wdata_i;
  assign m_wen_o   = req_i & we_i;
  assign m_ren_o   = req_i & ~we_i;
  assign active    = req_i | busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (active) begin
        if (m_ack_i || m_err_i) begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          err_q   <= m_err_i;
          rdata_q <= m_rdata_i;
          cnt_q   <= '0;
        end else if (cnt_q == CntW'(BusTo - 1)) begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          err_q   <= 1'b1;
          rdata_q <= m_rdata_i;
          cnt_q   <= '0;
        end else begin
          busy_q <= 1'b1;
          cnt_q  <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign done_o  = done_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/red_pitaya_counter_scan_ctrl.sv
// Autonomous scan sequencer: runs N countImmediately acquisitions on the counter
// and streams the ch1/ch2 totals of each run as one result beat.
module red_pitaya_counter_scan_ctrl
  import red_pitaya_counter_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned POLL_GAP = 16,
  parameter int unsigned BUS_TO   = 64
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [15:0]   i_nruns,
  input  logic [31:0]   i_timeout,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [15:0]   o_run_idx,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_wen,
  output logic          m_ren,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  input  logic          m_err,
  output logic          o_res_valid,
  input  logic          i_res_ready,
  output logic [31:0]   o_res_ch1,
  output logic [31:0]   o_res_ch2,
  output logic [15:0]   o_res_idx
);

  scan_state_e   state_q;
  bus_req_t      breq_q;
  logic          req_q;
  logic [15:0]   nruns_q, run_idx_q, gap_q, res_idx_q;
  logic [31:0]   res_ch1_q, res_ch2_q;
  logic          abort_q, done_q, err_q, res_valid_q;
  logic          bm_done, bm_err;
  logic [DW-1:0] bm_rdata;
  logic          busy, abort_now, last_run;

  assign busy      = !(state_q inside {StIdle, StDone, StError});
  assign abort_now = abort_q | i_abort;
  assign last_run  = (run_idx_q == nruns_q - 16'd1);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= StIdle;
      breq_q      <= '0;
      req_q       <= 1'b0;
      nruns_q     <= '0;
      run_idx_q   <= '0;
      gap_q       <= '0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch1_q   <= '0;
      res_ch2_q   <= '0;
      res_idx_q   <= '0;
    end else begin
      req_q <= 1'b0;
      if (i_abort && busy) abort_q <= 1'b1;
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (i_start && !i_abort) begin
            nruns_q   <= (i_nruns == 16'd0) ? 16'd1 : i_nruns;
            run_idx_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
            req_q     <= 1'b1;
            breq_q    <= bus_wr(RegTimeout, i_timeout);
            state_q   <= StWrTo;
          end
        end
        StWait: begin
          if (abort_now) begin
            abort_q <= 1'b0;
            req_q   <= 1'b1;
            breq_q  <= bus_wr(RegCmd, CmdReset);
            state_q <= StAbort;
          end else if (gap_q == 16'(POLL_GAP - 1)) begin
            req_q   <= 1'b1;
            breq_q  <= bus_rd(RegCmd);
            state_q <= StPoll;
          end else begin
            gap_q <= gap_q + 16'd1;
          end
        end
        StPush: begin
          // An abort discards the beat still waiting for ready.
          if (abort_now) begin
            res_valid_q <= 1'b0;
            abort_q     <= 1'b0;
            req_q       <= 1'b1;
            breq_q      <= bus_wr(RegCmd, CmdReset);
            state_q     <= StAbort;
          end else if (i_res_ready) begin
            res_valid_q <= 1'b0;
            if (last_run) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              run_idx_q <= run_idx_q + 16'd1;
              req_q     <= 1'b1;
              breq_q    <= bus_wr(RegCmd, CmdReset);
              state_q   <= StClr;
            end
          end
        end
        default: begin
          // Bus states: decisions are taken only once the transaction has completed.
          if (bm_done) begin
            if (bm_err) begin
              err_q   <= 1'b1;
              abort_q <= 1'b0;
              state_q <= StError;
            end else if (abort_now && state_q != StAbort) begin
              abort_q <= 1'b0;
              req_q   <= 1'b1;
              breq_q  <= bus_wr(RegCmd, CmdReset);
              state_q <= StAbort;
            end else begin
              case (state_q)
                StWrTo: begin
                  req_q   <= 1'b1;
                  breq_q  <= bus_wr(RegCmd, CmdReset);
                  state_q <= StClr;
                end
                StClr: begin
                  req_q   <= 1'b1;
                  breq_q  <= bus_wr(RegCmd, CmdImmediate);
                  state_q <= StArm;
                end
                StArm: begin
                  gap_q   <= '0;
                  state_q <= StWait;
                end
                StPoll: begin
                  gap_q <= '0;
                  if (bm_rdata == '0) begin
                    req_q   <= 1'b1;
                    breq_q  <= bus_rd(RegCh1);
                    state_q <= StRd1;
                  end else begin
                    state_q <= StWait;
                  end
                end
                StRd1: begin
                  res_ch1_q <= 32'(bm_rdata);
                  req_q     <= 1'b1;
                  breq_q    <= bus_rd(RegCh2);
                  state_q   <= StRd2;
                end
                StRd2: begin
                  res_ch2_q   <= 32'(bm_rdata);
                  res_idx_q   <= run_idx_q;
                  res_valid_q <= 1'b1;
                  state_q     <= StPush;
                end
                StAbort: begin
                  abort_q <= 1'b0;
                  done_q  <= 1'b0;
                  state_q <= StIdle;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  red_pitaya_bus_master #(
    .AW    (AW),
    .DW    (DW),
    .BusTo (BUS_TO)
  ) u_bus_master (
    .clk_i     (i_clk),
    .rst_ni    (i_rstn),
    .req_i     (req_q),
    .we_i      (breq_q.we),
    .addr_i    (AW'(breq_q.addr)),
    .wdata_i   (DW'(breq_q.wdata)),
    .m_addr_o  (m_addr),
    .m_wdata_o (m_wdata),
    .m_wen_o   (m_wen),
    .m_ren_o   (m_ren),
    .m_rdata_i (m_rdata),
    .m_ack_i   (m_ack),
    .m_err_i   (m_err),
    .done_o    (bm_done),
    .err_o     (bm_err),
    .rdata_o   (bm_rdata)
  );

  assign o_busy      = busy;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_run_idx   = run_idx_q;
  assign o_res_valid = res_valid_q;
  assign o_res_ch1   = res_ch1_q;
  assign o_res_ch2   = res_ch2_q;
  assign o_res_idx   = res_idx_q;

endmodule

// File: tb/tb_red_pitaya_counter_scan_ctrl.sv
// Bench for the scan sequencer against a small behavioural model of the counter slave.
module tb_red_pitaya_counter_scan_ctrl;

  localparam int unsigned BusTo = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [15:0] nruns = 16'd1;
  logic [31:0] tmo = 32'd100;
  logic        i_res_ready = 1'b1;
  logic        o_busy, o_done, o_err, o_res_valid;
  logic [15:0] o_run_idx, o_res_idx;
  logic [31:0] o_res_ch1, o_res_ch2;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_wen, m_ren, m_ack, m_err;

  always #4 clk = ~clk;
  assign m_err = 1'b0;

  red_pitaya_counter_scan_ctrl #(
    .AW       (32),
    .DW       (32),
    .POLL_GAP (16),
    .BUS_TO   (BusTo)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rst_n),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_nruns     (nruns),
    .i_timeout   (tmo),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_run_idx   (o_run_idx),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_wen       (m_wen),
    .m_ren       (m_ren),
    .m_rdata     (m_rdata),
    .m_ack       (m_ack),
    .m_err       (m_err),
    .o_res_valid (o_res_valid),
    .i_res_ready (i_res_ready),
    .o_res_ch1   (o_res_ch1),
    .o_res_ch2   (o_res_ch2),
    .o_res_idx   (o_res_idx)
  );

  // Counter model: ack one cycle after a strobe; ch1 += 1 and ch2 += 2 per counting cycle.
  logic        no_ack = 1'b0;
  logic        outst;
  logic [31:0] c_state, c_remain, c_tmo, c_ch1, c_ch2, last_waddr, last_wdata;
  int          n_rst_wr, n_arm_wr, n_tmo_wr, n_strobe, n_overlap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ack <= 1'b0; m_rdata <= '0; outst <= 1'b0;
      c_state <= '0; c_remain <= '0; c_tmo <= '0; c_ch1 <= '0; c_ch2 <= '0;
      last_waddr <= '1; last_wdata <= '1;
      n_rst_wr <= 0; n_arm_wr <= 0; n_tmo_wr <= 0; n_strobe <= 0; n_overlap <= 0;
    end else begin
      m_ack <= 1'b0;
      if ((m_wen || m_ren) && outst && !m_ack) n_overlap <= n_overlap + 1;
      if (m_ack) outst <= 1'b0;
      if (m_wen || m_ren) begin
        n_strobe <= n_strobe + 1;
        if (!no_ack) begin
          m_ack <= 1'b1;
          outst <= 1'b1;
        end
      end
      if (m_ren) begin
        case (m_addr)
          32'h00:  m_rdata <= c_state;
          32'h08:  m_rdata <= c_ch1;
          32'h1C:  m_rdata <= c_ch2;
          default: m_rdata <= '0;
        endcase
      end
      if (m_wen) begin
        last_waddr <= m_addr;
        last_wdata <= m_wdata;
        if (m_addr == 32'h04) begin
          c_tmo    <= m_wdata;
          n_tmo_wr <= n_tmo_wr + 1;
        end else if (m_addr == 32'h00 && m_wdata == 32'h02) begin
          c_state  <= '0; c_ch1 <= '0; c_ch2 <= '0;
          n_rst_wr <= n_rst_wr + 1;
        end else if (m_addr == 32'h00 && m_wdata == 32'h03) begin
          c_state  <= 32'd1;
          c_remain <= c_tmo;
          n_arm_wr <= n_arm_wr + 1;
        end
      end else if (c_state == 32'd1) begin
        if (c_remain == 0) begin
          c_state <= '0;
        end else begin
          c_ch1    <= c_ch1 + 32'd1;
          c_ch2    <= c_ch2 + 32'd2;
          c_remain <= c_remain - 32'd1;
        end
      end
    end
  end

  int          nbeats = 0;
  logic [31:0] b_ch1 [8];
  logic [31:0] b_ch2 [8];
  logic [15:0] b_idx [8];

  always @(posedge clk) begin
    if (rst_n && o_res_valid && i_res_ready) begin
      b_ch1[nbeats % 8] <= o_res_ch1;
      b_ch2[nbeats % 8] <= o_res_ch2;
      b_idx[nbeats % 8] <= o_res_idx;
      nbeats <= nbeats + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int base_beats, base_rst, base_arm, base_tmo, base_strobe;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    base_beats  = nbeats;
    base_rst    = n_rst_wr;
    base_arm    = n_arm_wr;
    base_tmo    = n_tmo_wr;
    base_strobe = n_strobe;
  endtask

  task automatic pulse(input logic s, input logic a);
    @(negedge clk);
    i_start = s;
    i_abort = a;
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 64'(o_busy), 64'd0);
  endtask

  // Expects the last completed scan to have produced `runs` beats of 100/200.
  task automatic check_beats(input string tag, input int runs);
    check_val({tag, "_nbeats"}, 64'(nbeats - base_beats), 64'(runs));
    for (int k = 0; k < runs; k++) begin
      check_val({tag, "_ch1"}, 64'(b_ch1[(base_beats + k) % 8]), 64'd100);
      check_val({tag, "_ch2"}, 64'(b_ch2[(base_beats + k) % 8]), 64'd200);
      check_val({tag, "_idx"}, 64'(b_idx[(base_beats + k) % 8]), 64'(k));
    end
  endtask

  initial begin
    logic [31:0] sv_ch1, sv_ch2;
    logic [15:0] sv_idx;
    logic        stable;
    int          s0, cyc;

    repeat (3) @(negedge clk);
    check_val("rst_busy", 64'(o_busy), 64'd0);
    check_val("rst_done", 64'(o_done), 64'd0);
    check_val("rst_err", 64'(o_err), 64'd0);
    check_val("rst_valid", 64'(o_res_valid), 64'd0);
    check_val("rst_strobe", 64'({m_wen, m_ren}), 64'd0);
    check_val("rst_addr", 64'(m_addr), 64'd0);
    check_val("rst_run_idx", 64'(o_run_idx), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single run, first strobe one cycle after start
    nruns = 16'd1; tmo = 32'd100; i_res_ready = 1'b1; snap();
    @(negedge clk); i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    check_val("t1_lat_wen", 64'(m_wen), 64'd1);
    check_val("t1_lat_addr", 64'(m_addr), 64'h04);
    check_val("t1_lat_wdata", 64'(m_wdata), 64'd100);
    wait_idle("t1_idle", 2000);
    check_beats("t1", 1);
    check_val("t1_done", 64'(o_done), 64'd1);
    check_val("t1_err", 64'(o_err), 64'd0);
    check_val("t1_rst_wr", 64'(n_rst_wr - base_rst), 64'd1);
    check_val("t1_arm_wr", 64'(n_arm_wr - base_arm), 64'd1);

    // 2: three runs, one reset and one arm write per run
    nruns = 16'd3; snap();
    pulse(1'b1, 1'b0);
    check_val("t2_done_clr", 64'(o_done), 64'd0);
    wait_idle("t2_idle", 4000);
    check_beats("t2", 3);
    check_val("t2_done", 64'(o_done), 64'd1);
    check_val("t2_rst_wr", 64'(n_rst_wr - base_rst), 64'd3);
    check_val("t2_arm_wr", 64'(n_arm_wr - base_arm), 64'd3);

    // 3: back-pressure holds the beat and stalls the bus
    nruns = 16'd2; i_res_ready = 1'b0; snap();
    pulse(1'b1, 1'b0);
    cyc = 0;
    while (!o_res_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_val("t3_valid", 64'(o_res_valid), 64'd1);
    sv_ch1 = o_res_ch1; sv_ch2 = o_res_ch2; sv_idx = o_res_idx; s0 = n_strobe; stable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!o_res_valid || o_res_ch1 !== sv_ch1 || o_res_ch2 !== sv_ch2 || o_res_idx !== sv_idx)
        stable = 1'b0;
    end
    check_val("t3_stable", 64'(stable), 64'd1);
    check_val("t3_no_strobe", 64'(n_strobe - s0), 64'd0);
    check_val("t3_held_ch1", 64'(sv_ch1), 64'd100);
    i_res_ready = 1'b1;
    wait_idle("t3_idle", 2000);
    check_beats("t3", 2);
    check_val("t3_done", 64'(o_done), 64'd1);

    // 4: abort 30 cycles after start
    nruns = 16'd1; snap();
    pulse(1'b1, 1'b0);
    repeat (28) @(negedge clk);
    pulse(1'b0, 1'b1);
    wait_idle("t4_idle", 500);
    check_val("t4_done", 64'(o_done), 64'd0);
    check_val("t4_err", 64'(o_err), 64'd0);
    check_val("t4_nbeats", 64'(nbeats - base_beats), 64'd0);
    check_val("t4_last_wr", 64'({last_waddr, last_wdata}), {32'h00, 32'h02});
    check_val("t4_rst_wr", 64'(n_rst_wr - base_rst), 64'd2);
    check_val("t4_overlap", 64'(n_overlap), 64'd0);

    // 5: silent slave trips the watchdog; error cycle = 64-cycle window + 1 to register
    no_ack = 1'b1; snap();
    @(negedge clk); i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    cyc = 0;
    while (!o_err && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val("t5_to_cycles", 64'(cyc), 64'(BusTo + 1));
    check_val("t5_busy", 64'(o_busy), 64'd0);
    repeat (20) @(negedge clk);
    check_val("t5_strobes", 64'(n_strobe - base_strobe), 64'd1);
    check_val("t5_err_sticky", 64'(o_err), 64'd1);
    no_ack = 1'b0; snap();
    @(negedge clk); i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    check_val("t5_err_clr", 64'(o_err), 64'd0);
    wait_idle("t5_idle", 2000);
    check_val("t5_done", 64'(o_done), 64'd1);
    check_beats("t5", 1);

    // 6: start while busy is ignored; start+abort collision aborts
    nruns = 16'd2; snap();
    pulse(1'b1, 1'b0);
    repeat (8) @(negedge clk);
    pulse(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check_val("t6_busy", 64'(o_busy), 64'd1);
    check_val("t6_tmo_wr", 64'(n_tmo_wr - base_tmo), 64'd1);
    pulse(1'b1, 1'b1);
    wait_idle("t6_idle", 500);
    check_val("t6_done", 64'(o_done), 64'd0);
    check_val("t6_nbeats", 64'(nbeats - base_beats), 64'd0);
    check_val("t6_tmo_wr_end", 64'(n_tmo_wr - base_tmo), 64'd1);
    check_val("t6_last_wr", 64'({last_waddr, last_wdata}), {32'h00, 32'h02});

    // 7: nruns of zero runs once
    nruns = 16'd0; snap();
    pulse(1'b1, 1'b0);
    wait_idle("t7_idle", 2000);
    check_beats("t7", 1);
    check_val("t7_done", 64'(o_done), 64'd1);
    check_val("end_overlap", 64'(n_overlap), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
